// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator and the sprite renderers.
// The generator is the master; renderers and pin drivers are slaves.
interface vga_timing_gen_if;
    logic       pixel_en;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       frame_start;
    logic       blank_d;
    logic       hs_d;
    logic       vs_d;

    modport master (
        input  pixel_en,
        output DrawX,
        output DrawY,
        output blank,
        output hs,
        output vs,
        output frame_start,
        output blank_d,
        output hs_d,
        output vs_d
    );

    modport slave (
        output pixel_en,
        input  DrawX,
        input  DrawY,
        input  blank,
        input  hs,
        input  vs,
        input  frame_start,
        input  blank_d,
        input  hs_d,
        input  vs_d
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: DrawX/DrawY counters, blank/sync, frame pulse,
// plus sync/blank copies delayed to match registered sprite outputs.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FP + V_SYNC);

    // {blank, hs, vs} as held during reset
    localparam logic [2:0]  IDLE_BHV = 3'b011;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counters");
        end
        if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY must be 1..4");
        end
    endgenerate

    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] hc_nxt;
    logic [9:0] vc_nxt;
    logic [10:0] hx_nxt;
    logic [10:0] vy_nxt;
    logic       blank_nxt;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       blank_q;
    logic       hs_q;
    logic       vs_q;
    logic       fs_q;
    logic [2:0] dly [PIPE_DELAY];

    always_comb begin
        hc_nxt = hc + 10'd1;
        vc_nxt = vc;
        if (hc == H_LAST) begin
            hc_nxt = 10'd0;
            vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end
    end

    // Flags are decoded from the next position so they line up with it
    always_comb begin
        hx_nxt    = {1'b0, hc_nxt};
        vy_nxt    = {1'b0, vc_nxt};
        blank_nxt = (hx_nxt < H_VIS) && (vy_nxt < V_VIS);
        hs_nxt    = !((hx_nxt >= HS_BEG) && (hx_nxt < HS_END));
        vs_nxt    = !((vy_nxt >= VS_BEG) && (vy_nxt < VS_END));
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc      <= H_LAST;
            vc      <= V_LAST;
            blank_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else if (bus.pixel_en) begin
            hc      <= hc_nxt;
            vc      <= vc_nxt;
            blank_q <= blank_nxt;
            hs_q    <= hs_nxt;
            vs_q    <= vs_nxt;
            fs_q    <= (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
        end else begin
            fs_q    <= 1'b0;
        end
    end

    // Shifts every clock: sprite pipelines register per clock, not per pixel
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                dly[i] <= IDLE_BHV;
            end
        end else begin
            dly[0] <= {blank_q, hs_q, vs_q};
            for (int i = 1; i < PIPE_DELAY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign bus.DrawX       = hc;
    assign bus.DrawY       = vc;
    assign bus.blank       = blank_q;
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.frame_start = fs_q;
    assign bus.blank_d     = dly[PIPE_DELAY-1][2];
    assign bus.hs_d        = dly[PIPE_DELAY-1][1];
    assign bus.vs_d        = dly[PIPE_DELAY-1][0];
endmodule
